// File: rtl/regfile_write_port.sv
// regfile_write_port: merges pipeline writeback and a buffered mul/div result stream onto one register-file write port.
// Optional forwarding lookup is compiled in when WB_FWD_EN is defined.
module regfile_write_port #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [ADDR_W-1:0]        md_addr,
  input  logic [DATA_W-1:0]        md_data,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        write_addr,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        fwd_addr_1,
  input  logic [ADDR_W-1:0]        fwd_addr_2,
  output logic                     fwd_hit_1,
  output logic                     fwd_hit_2,
  output logic [DATA_W-1:0]        fwd_data_1,
  output logic [DATA_W-1:0]        fwd_data_2,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              reg_write_q;
  logic [ADDR_W-1:0] write_addr_q;
  logic [DATA_W-1:0] write_data_q;
  logic              wb_issue, push, pop, head_vld;

  assign md_ready = count_q < CW'(DEPTH);
  assign wb_issue = wb_valid && (wb_addr != '0);
  assign push     = md_valid && md_ready && (md_addr != '0);
  assign pop      = !wb_issue && (count_q != '0);
  assign head_vld = vld_q[rd_ptr_q];
  assign count_d  = count_q + CW'(push) - CW'(pop);

  // A same-cycle push is applied after the cancel so the newer md result survives.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++)
      if (wb_issue && addr_q[i] == wb_addr) vld_d[i] = 1'b0;
    if (pop) vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      vld_q       <= vld_d;
      count_q     <= count_d;
      reg_write_q <= wb_issue || (pop && head_vld);
      if (push) begin
        addr_q[wr_ptr_q] <= md_addr;
        data_q[wr_ptr_q] <= md_data;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (wb_issue) begin
        write_addr_q <= wb_addr;
        write_data_q <= wb_data;
      end else if (pop && head_vld) begin
        write_addr_q <= addr_q[rd_ptr_q];
        write_data_q <= data_q[rd_ptr_q];
      end
    end
  end

  assign RegWrite   = reg_write_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign fifo_count = count_q;

`ifdef WB_FWD_EN
  // Walk oldest to newest so the last match (newest pending write) wins; popped slots are always invalid.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
    logic [DATA_W:0] r;
    logic [PW-1:0]   idx;
    r = (reg_write_q && write_addr_q == a) ? {1'b1, write_data_q} : '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (vld_q[idx] && addr_q[idx] == a) r = {1'b1, data_q[idx]};
    end
    return (a == '0) ? '0 : r;
  endfunction

  always_comb begin
    {fwd_hit_1, fwd_data_1} = lookup(fwd_addr_1);
    {fwd_hit_2, fwd_data_2} = lookup(fwd_addr_2);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_addr_1, fwd_addr_2};
  assign fwd_hit_1  = 1'b0;
  assign fwd_hit_2  = 1'b0;
  assign fwd_data_1 = '0;
  assign fwd_data_2 = '0;
`endif
endmodule

// File: tb/tb_regfile_write_port.sv
// tb_regfile_write_port: directed stimulus with an expected-write queue drained by an independent write monitor.
module tb_regfile_write_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0, md_valid = 1'b0;
  logic [4:0]  wb_addr = '0, md_addr = '0, fwd_addr_1 = '0, fwd_addr_2 = '0;
  logic [31:0] wb_data = '0, md_data = '0;
  logic        md_ready, RegWrite, fwd_hit_1, fwd_hit_2;
  logic [4:0]  write_addr;
  logic [31:0] write_data, fwd_data_1, fwd_data_2;
  logic [2:0]  fifo_count;
  logic [36:0] exp_q [$];
  logic [36:0] e;
  logic        mon_en = 1'b0;
  int          n_chk = 0, n_pass = 0;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  regfile_write_port dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
    .RegWrite(RegWrite), .write_addr(write_addr), .write_data(write_data),
    .fwd_addr_1(fwd_addr_1), .fwd_addr_2(fwd_addr_2),
    .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
    .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid = v; wb_addr = a; wb_data = d;
  endtask

  task automatic md(input logic v, input logic [4:0] a, input logic [31:0] d);
    md_valid = v; md_addr = a; md_data = d;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic fwd(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                     input logic h1, input logic [31:0] d1, input logic h2, input logic [31:0] d2);
    fwd_addr_1 = a1; fwd_addr_2 = a2;
    #1;
    chk({tag, " hit1"}, fwd_hit_1, FWD & h1);
    chk({tag, " data1"}, fwd_data_1, FWD ? d1 : 32'h0);
    chk({tag, " hit2"}, fwd_hit_2, FWD & h2);
    chk({tag, " data2"}, fwd_data_2, FWD ? d2 : 32'h0);
  endtask

  // Every issued write must match the next expected write, in order.
  always @(negedge clk) begin
    if (mon_en && RegWrite) begin
      if (exp_q.size() == 0) begin
        chk("unexpected write addr", {32'h0, write_addr}, 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write addr", write_addr, e[36:32]);
        chk("write data", write_data, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    mon_en = 1'b1;
    chk("rst RegWrite", RegWrite, 0);
    chk("rst write_addr", write_addr, 0);
    chk("rst write_data", write_data, 0);
    chk("rst fifo_count", fifo_count, 0);
    chk("rst md_ready", md_ready, 1);
    tick();
    chk("idle RegWrite", RegWrite, 0);

    wb(1, 5'd8, 32'h1234); expect_wr(5'd8, 32'h1234);
    tick(); wb(0, 0, 0);
    tick();
    chk("wb single then idle", RegWrite, 0);
    wb(1, 5'd0, 32'hDEAD);
    tick(); wb(0, 0, 0);
    chk("wb addr0 no write", RegWrite, 0);

    for (int k = 0; k < 4; k++) begin
      wb(1, 5'(20 + k), 32'h100 + k); expect_wr(5'(20 + k), 32'h100 + k);
      md(1, 5'(3 + k), 32'hA + k);
      tick();
    end
    chk("full md_ready", md_ready, 0);
    chk("full count", fifo_count, 4);
    wb(1, 5'd24, 32'h104); expect_wr(5'd24, 32'h104);
    md(1, 5'd11, 32'hEE);
    tick();
    chk("stalled push count", fifo_count, 4);
    wb(0, 0, 0); md(0, 0, 0);
    for (int k = 0; k < 4; k++) expect_wr(5'(3 + k), 32'hA + k);
    tick(); tick(); tick(); tick();
    chk("drained count", fifo_count, 0);
    chk("drained md_ready", md_ready, 1);
    tick();
    chk("drained RegWrite", RegWrite, 0);

    md(1, 5'd9, 32'h55);
    tick(); md(0, 0, 0);
    chk("r9 queued", fifo_count, 1);
    wb(1, 5'd9, 32'h77); expect_wr(5'd9, 32'h77);
    tick(); wb(0, 0, 0);
    tick();
    chk("cancelled pop RegWrite", RegWrite, 0);
    chk("cancelled pop count", fifo_count, 0);

    wb(1, 5'd10, 32'h1); md(1, 5'd10, 32'h2);
    expect_wr(5'd10, 32'h1); expect_wr(5'd10, 32'h2);
    tick(); wb(0, 0, 0); md(0, 0, 0);
    tick(); tick();
    chk("same-cycle drained", fifo_count, 0);

    wb(1, 5'd7, 32'h33); md(1, 5'd7, 32'h11); expect_wr(5'd7, 32'h33);
    tick(); wb(0, 0, 0); md(0, 0, 0);
    fwd("fwd A", 5'd7, 5'd0, 1, 32'h11, 0, 32'h0);
    wb(1, 5'd12, 32'h5); md(1, 5'd7, 32'h22); expect_wr(5'd12, 32'h5);
    tick(); wb(0, 0, 0); md(0, 0, 0);
    fwd("fwd B", 5'd7, 5'd12, 1, 32'h22, 1, 32'h5);
    expect_wr(5'd7, 32'h11); expect_wr(5'd7, 32'h22);
    tick();
    fwd("fwd C", 5'd7, 5'd13, 1, 32'h22, 0, 32'h0);
    tick();
    fwd("fwd D", 5'd7, 5'd0, 1, 32'h22, 0, 32'h0);
    tick();
    fwd("fwd E", 5'd7, 5'd12, 0, 32'h0, 0, 32'h0);

    for (int k = 0; k < 3; k++) begin
      wb(1, 5'd15, 32'h200 + k); expect_wr(5'd15, 32'h200 + k);
      md(1, 5'(1 + k), 32'h30 + k);
      tick();
    end
    wb(0, 0, 0); md(0, 0, 0);
    chk("pre-reset count", fifo_count, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid reset count", fifo_count, 0);
    chk("mid reset RegWrite", RegWrite, 0);
    chk("mid reset md_ready", md_ready, 1);
    repeat (6) tick();
    chk("post reset count", fifo_count, 0);
    chk("all writes seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
